bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares the daisy-chained register bus between two host bridges, requester 0 and requester 1.
- The bus is the 16-bit addr/wdata/rdata/rw/valid chain threaded through the io cores.
- Issues one transaction at a time into the chain head and waits for it to emerge at the chain tail.
- Returns the completion, with read data or a timeout error, to the owning requester; arbitration is round-robin.

Parameters:
TIMEOUT, 1023, max WAIT cycles for a transaction to return before it completes with error (range 1..65535)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req0_addr_i  input  16  requester 0 address
req0_wdata_i  input  16  requester 0 write data
req0_rw_i  input  1  requester 0 direction, 1=write, 0=read
req0_valid_i  input  1  requester 0 has a transaction
req0_ready_o  output  1  requester 0 transaction accepted this cycle when valid&ready
req0_rdata_o  output  16  completion data to requester 0
req0_rvalid_o  output  1  one-cycle completion pulse to requester 0
req0_err_o  output  1  completion was a timeout, qualified by req0_rvalid_o
req1_* (same seven signals)  as above  as above  requester 1
addr_o  output  16  chain head address
wdata_o  output  16  chain head write data
rdata_o  output  16  chain head read data, always 0
rw_o  output  1  chain head direction
valid_o  output  1  chain head strobe
addr_i  input  16  chain tail address
wdata_i  input  16  chain tail write data, unused
rdata_i  input  16  chain tail read data
rw_i  input  1  chain tail direction
valid_i  input  1  chain tail strobe

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; round-robin pointer = 0; timeout counter 0.
  - Capture registers (addr, wdata, rw, owner) 0.
- States and transitions:
  - IDLE:
    - Grant goes to the pointer requester if its valid is high, else to the other requester if its valid is high.
    - reqN_ready_o is combinational: (state==IDLE) & grant==N.
    - On handshake: capture addr/wdata/rw/owner, then go to ISSUE.
  - ISSUE, one cycle:
    - valid_o=1; addr_o/wdata_o/rw_o = captured values; rdata_o=0.
    - Counter cleared; next state WAIT.
  - WAIT:
    - valid_o=0; bus outputs hold their last values.
    - Each cycle, match = valid_i & addr_i==captured addr & rw_i==captured rw.
    - On match: next cycle pulse owner rvalid=1, err=0; rdata = rdata_i for reads, 0 for writes.
    - Without match: counter increments.
    - If the counter reaches TIMEOUT without a match: next cycle pulse owner rvalid=1, err=1, rdata=0.
    - A match in the same cycle as the timeout wins.
    - Either exit: state RESP.
  - RESP, one cycle:
    - Owner rvalid/err/rdata registered outputs are asserted during this cycle only.
    - Pointer := owner ^ 1; next state IDLE.
- Latency:
  - Handshake in cycle T; valid_o in T+1.
  - With chain depth D (one cycle per core), return at T+1+D; rvalid at T+2+D.
  - Next handshake at T+3+D at the earliest.
- Fairness: with both valid continuously, grants alternate 0,1,0,1.
- Holding: a non-granted requester holds its valid and fields until ready.
- rdata_o width rule: always 0.
- Stray returns:
  - valid_i in IDLE/ISSUE/RESP is ignored.
  - valid_i in WAIT with a mismatched addr/rw is ignored; the counter keeps running.
- Reset mid-operation: any state returns to IDLE in the next cycle. The pending transaction is dropped, no rvalid is emitted, and the pointer returns to 0.
- rdata outputs: hold their value when rvalid=0; err cleared when rvalid=0.

Decomposition:
- Shared package bus_pkg:
  - BUS_WIDTH=16.
  - State enum {IDLE, ISSUE, WAIT, RESP}.
  - Transaction struct {addr, wdata, rw}.
- One natural sub-module, bus_timeout_counter:
  - Parameter TIMEOUT; ports clear, enable, expired.
  - Reused later by other bus masters.
- Arbitration and FSM stay in bus_arbiter.

Test Plan:
- Read, chain model D=2, addr 0x0001 returns rdata_i=0x0055 -> valid_o 1 cycle after handshake; req0_rvalid_o with rdata 0x0055, err 0, 4 cycles after handshake.
- Write req1 addr 0x0005 wdata 0x001F -> chain head shows addr 0x0005, wdata 0x001F, rw 1 for exactly 1 cycle; req1_rvalid_o with rdata 0; req0 sees nothing.
- Both valid from reset, 4 transactions each -> grant order 0,1,0,1,...; never two outstanding transactions on the chain.
- TIMEOUT=8, chain never returns -> req0_rvalid_o with err=1, rdata=0 exactly 10 cycles after handshake; next request proceeds normally.
- Stray valid_i addr 0x0007 during WAIT for addr 0x0002, then the correct return -> only the correct return completes, with its rdata.
- rst asserted for 1 cycle during WAIT -> all outputs 0 next cycle; late return ignored; no rvalid; fresh request served.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the register-bus masters: word width, arbiter FSM states and
// the captured transaction fields.
package bus_pkg;

    localparam int unsigned BUS_WIDTH = 16;

    typedef logic [BUS_WIDTH-1:0] bus_word_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } bus_state_e;

    typedef struct packed {
        bus_word_t addr;
        bus_word_t wdata;
        logic      rw;
    } bus_txn_t;

    // Round-robin successor of a two-requester owner id.
    function automatic logic next_owner(input logic owner);
        return ~owner;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter for an outstanding bus transaction. 'expired' fires in the
// TIMEOUT-th enabled cycle after 'clear', i.e. when the count is about to reach
// TIMEOUT.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LastCount = 16'(TIMEOUT - 1);

    logic [15:0] count_q, count_d;

    // Next count: clear wins, otherwise count while enabled without wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LastCount);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares the daisy-chained register bus between two
// host bridges. One transaction at a time is launched into the chain head and
// matched at the chain tail by addr/rw; a missing return completes with err.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [15:0]     req0_addr_i,
    input  logic [15:0]     req0_wdata_i,
    input  logic            req0_rw_i,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    output logic [15:0]     req0_rdata_o,
    output logic            req0_rvalid_o,
    output logic            req0_err_o,

    input  logic [15:0]     req1_addr_i,
    input  logic [15:0]     req1_wdata_i,
    input  logic            req1_rw_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    output logic [15:0]     req1_rdata_o,
    output logic            req1_rvalid_o,
    output logic            req1_err_o,

    output logic [15:0]     addr_o,
    output logic [15:0]     wdata_o,
    output logic [15:0]     rdata_o,
    output logic            rw_o,
    output logic            valid_o,

    input  logic [15:0]     addr_i,
    input  logic [15:0]     wdata_i,
    input  logic [15:0]     rdata_i,
    input  logic            rw_i,
    input  logic            valid_i
);

    bus_state_e state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       owner_q, owner_d;
    bus_txn_t   cap_q, cap_d;

    logic       rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic       err0_q, err0_d, err1_q, err1_d;
    bus_word_t  rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic       grant_valid;
    logic       grant_id;
    bus_txn_t   sel_txn;
    logic       match;
    logic       cnt_clear;
    logic       cnt_enable;
    logic       cnt_expired;

    // Write data returning at the chain tail carries nothing we need.
    logic       unused_wdata;
    assign unused_wdata = ^wdata_i;

    // Grant selection: pointer requester first, otherwise the other one.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ptr_q;
        if (ptr_q == 1'b0) begin
            if (req0_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end else begin
            if (req1_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end else if (req0_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end
        end

        if (grant_id) begin
            sel_txn = '{addr: req1_addr_i, wdata: req1_wdata_i, rw: req1_rw_i};
        end else begin
            sel_txn = '{addr: req0_addr_i, wdata: req0_wdata_i, rw: req0_rw_i};
        end
    end

    assign req0_ready_o = (state_q == StIdle) && grant_valid && (grant_id == 1'b0);
    assign req1_ready_o = (state_q == StIdle) && grant_valid && (grant_id == 1'b1);

    assign match = valid_i && (addr_i == cap_q.addr) && (rw_i == cap_q.rw);

    // FSM next state, capture and completion registers; defaults first.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cap_d      = cap_q;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    cap_d   = sel_txn;
                    owner_d = grant_id;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_clear = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                cnt_enable = 1'b1;
                // A return in the expiring cycle still counts as a good completion.
                if (match || cnt_expired) begin
                    state_d = StResp;
                    if (owner_q) begin
                        rvalid1_d = 1'b1;
                        err1_d    = !match;
                        rdata1_d  = (match && !cap_q.rw) ? rdata_i : '0;
                    end else begin
                        rvalid0_d = 1'b1;
                        err0_d    = !match;
                        rdata0_d  = (match && !cap_q.rw) ? rdata_i : '0;
                    end
                end
            end
            StResp: begin
                ptr_d   = next_owner(owner_q);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset drops any pending transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            cap_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cap_q     <= cap_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    // Chain head mirrors the capture register so it holds between strobes.
    assign addr_o  = cap_q.addr;
    assign wdata_o = cap_q.wdata;
    assign rw_o    = cap_q.rw;
    assign valid_o = (state_q == StIssue);
    assign rdata_o = '0;

    assign req0_rvalid_o = rvalid0_q;
    assign req0_err_o    = err0_q;
    assign req0_rdata_o  = rdata0_q;
    assign req1_rvalid_o = rvalid1_q;
    assign req1_err_o    = err1_q;
    assign req1_rdata_o  = rdata1_q;

endmodule
